// File: rtl/timer.sv
// rtl/timer.sv - DMG timer/divider: DIV window, TIMA/TMA/TAC, delayed overflow reload and timer interrupt pulse
module timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        rd,
    input  logic        wr,
    output logic        int_tim_req
);

    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OVF    = 2'd1;
    localparam logic [1:0] ST_RELOAD = 2'd2;

    logic [15:0] div_cnt;
    logic [7:0]  tima;
    logic [7:0]  tma;
    logic [2:0]  tac;
    logic [1:0]  state;
    logic [1:0]  cnt;
    logic        prev_sig;

    logic        wr_div;
    logic        wr_tima;
    logic        wr_tma;
    logic        wr_tac;

    logic [15:0] div_next;
    logic [2:0]  tac_next;
    logic        tap;
    logic        sig;
    logic        inc;

    // Reads are not side-effecting, so the strobe carries no information here.
    logic        rd_unused;
    assign rd_unused = rd;

    assign wr_div  = wr && (a == ADDR_DIV);
    assign wr_tima = wr && (a == ADDR_TIMA);
    assign wr_tma  = wr && (a == ADDR_TMA);
    assign wr_tac  = wr && (a == ADDR_TAC);

    // The DIV clear overrides the free-running increment.
    assign div_next = wr_div ? 16'h0000 : div_cnt + 16'h0001;
    assign tac_next = wr_tac ? din[2:0] : tac;

    // Tap selection looks at the values that will exist after this edge, so a
    // DIV clear or TAC rewrite can itself produce a falling edge (DMG glitch).
    always_comb begin
        tap = 1'b0;
        case (tac_next[1:0])
            2'b00:   tap = div_next[9];
            2'b01:   tap = div_next[3];
            2'b10:   tap = div_next[5];
            default: tap = div_next[7];
        endcase
    end

    assign sig = tac_next[2] & tap;
    assign inc = prev_sig & ~sig;

    // Divider, control register and the edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= 16'h0000;
            tac      <= 3'b000;
            prev_sig <= 1'b0;
        end else begin
            div_cnt  <= div_next;
            tac      <= tac_next;
            prev_sig <= sig;
        end
    end

    // TMA accepts writes in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tma <= 8'h00;
        end else if (wr_tma) begin
            tma <= din;
        end
    end

    // TIMA counting, the 4-clock overflow window, the reload window and the interrupt pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tima        <= 8'h00;
            state       <= ST_IDLE;
            cnt         <= 2'd0;
            int_tim_req <= 1'b0;
        end else begin
            int_tim_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_tima) begin
                        // A CPU write beats a coincident increment and suppresses overflow.
                        tima <= din;
                    end else if (inc) begin
                        if (tima == 8'hFF) begin
                            tima  <= 8'h00;
                            state <= ST_OVF;
                            cnt   <= 2'd3;
                        end else begin
                            tima <= tima + 8'h01;
                        end
                    end
                end
                ST_OVF: begin
                    if (wr_tima) begin
                        // Writing TIMA while it still reads 00 cancels the pending reload.
                        tima  <= din;
                        state <= ST_IDLE;
                        cnt   <= 2'd0;
                    end else if (cnt == 2'd0) begin
                        // Reload from the newest TMA, including one written this very cycle.
                        tima        <= wr_tma ? din : tma;
                        int_tim_req <= 1'b1;
                        state       <= ST_RELOAD;
                        cnt         <= 2'd3;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ST_RELOAD: begin
                    // TIMA is locked to TMA here: TIMA writes are dropped, TMA writes land in both.
                    if (wr_tma) begin
                        tima <= din;
                    end
                    if (cnt == 2'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    // Read mux; unimplemented TAC bits and unmapped addresses read as ones.
    always_comb begin
        dout = 8'hFF;
        case (a)
            ADDR_DIV:  dout = div_cnt[15:8];
            ADDR_TIMA: dout = tima;
            ADDR_TMA:  dout = tma;
            ADDR_TAC:  dout = {5'b11111, tac};
            default:   dout = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_timer.sv
// tb/tb_timer.sv - scoreboard testbench for the timer peripheral
module tb_timer;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd;
    logic        wr;
    logic        int_tim_req;

    int checks;
    int failures;
    int cyc;
    int pulses;

    logic [7:0] exp_q[$];
    string      name_q[$];
    int         int_q[$];

    logic [7:0] mon_e;
    string      mon_n;
    int         mon_c;

    timer dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .din         (din),
        .dout        (dout),
        .rd          (rd),
        .wr          (wr),
        .int_tim_req (int_tim_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read monitor: compare each presented read against the oldest queued expectation.
    always @(negedge clk) begin
        if (rd) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected cyc=%0d addr=%h got=%h required=none", cyc, a, dout);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (dout !== mon_e) begin
                    failures++;
                    $display("FAIL %s cyc=%0d addr=%h got=%h required=%h", mon_n, cyc, a, dout, mon_e);
                end
            end
        end
    end

    // Interrupt monitor: each pulse must match the next expected cycle.
    always @(negedge clk) begin
        if (!rst && int_tim_req) begin
            pulses++;
            checks++;
            if (int_q.size() == 0) begin
                failures++;
                $display("FAIL int_unexpected cyc=%0d got=1 required=0", cyc);
            end else begin
                mon_c = int_q.pop_front();
                if (cyc != mon_c) begin
                    failures++;
                    $display("FAIL int_cycle got=%0d required=%0d", cyc, mon_c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        pulses = 0;
    endtask

    task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
        a = addr;
        din = data;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        a = 16'h0000;
        din = 8'h00;
    endtask

    task automatic rd_chk(input logic [15:0] addr, input logic [7:0] exp, input string nm);
        a = addr;
        rd = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        tick();
        rd = 1'b0;
        a = 16'h0000;
    endtask

    task automatic end_test(input int exp_pulses, input string nm);
        checks++;
        if (pulses != exp_pulses || int_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pulses got=%0d required=%0d missing=%0d", nm, pulses, exp_pulses, int_q.size());
        end
        int_q.delete();
    endtask

    // Common setup: TMA=AB, TIMA=FE, TAC=101 written in cycles 0..2.
    task automatic setup_ab();
        do_reset();
        wr_reg(16'hFF06, 8'hAB);
        wr_reg(16'hFF05, 8'hFE);
        wr_reg(16'hFF07, 8'h05);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        pulses = 0;
        rst = 1'b1;
        a = 16'h0000;
        din = 8'h00;
        rd = 1'b0;
        wr = 1'b0;

        // Reset values
        do_reset();
        rd_chk(16'hFF04, 8'h00, "rst_div");
        rd_chk(16'hFF05, 8'h00, "rst_tima");
        rd_chk(16'hFF06, 8'h00, "rst_tma");
        rd_chk(16'hFF07, 8'hF8, "rst_tac");
        rd_chk(16'hFF08, 8'hFF, "rst_unmapped");
        end_test(0, "rst");

        // Full 256-tick run at /16 with TMA=20
        do_reset();
        wr_reg(16'hFF06, 8'h20);
        wr_reg(16'hFF07, 8'h05);
        int_q.push_back(4100);
        wait_until(15);
        rd_chk(16'hFF05, 8'h00, "run_c15");
        rd_chk(16'hFF05, 8'h01, "run_c16");
        wait_until(47);
        rd_chk(16'hFF05, 8'h02, "run_c47");
        rd_chk(16'hFF05, 8'h03, "run_c48");
        wait_until(4095);
        rd_chk(16'hFF05, 8'hFF, "run_ff");
        for (int i = 0; i < 4; i++) rd_chk(16'hFF05, 8'h00, "run_ovf");
        rd_chk(16'hFF05, 8'h20, "run_reload");
        wait_until(4111);
        rd_chk(16'hFF05, 8'h20, "run_hold");
        rd_chk(16'hFF05, 8'h21, "run_next");
        end_test(1, "run");

        // TMA=AB, TIMA=FE: overflow then reload with one pulse
        setup_ab();
        int_q.push_back(36);
        wait_until(16);
        rd_chk(16'hFF05, 8'hFF, "ab_ff16");
        wait_until(31);
        rd_chk(16'hFF05, 8'hFF, "ab_ff31");
        for (int i = 0; i < 4; i++) rd_chk(16'hFF05, 8'h00, "ab_ovf");
        rd_chk(16'hFF05, 8'hAB, "ab_reload");
        rd_chk(16'hFF05, 8'hAB, "ab_reload2");
        rd_chk(16'hFF06, 8'hAB, "ab_tma");
        end_test(1, "ab");

        // Abort: TIMA write in the 2nd OVF clock
        setup_ab();
        wait_until(32);
        rd_chk(16'hFF05, 8'h00, "abort_ovf1");
        wr_reg(16'hFF05, 8'h55);
        for (int i = 0; i < 4; i++) rd_chk(16'hFF05, 8'h55, "abort_hold");
        wait_until(47);
        rd_chk(16'hFF05, 8'h55, "abort_c47");
        rd_chk(16'hFF05, 8'h56, "abort_inc");
        end_test(0, "abort");

        // RELOAD window: TIMA write ignored, TMA write lands in both
        setup_ab();
        int_q.push_back(36);
        wait_until(36);
        rd_chk(16'hFF05, 8'hAB, "rl_first");
        wr_reg(16'hFF05, 8'h77);
        rd_chk(16'hFF05, 8'hAB, "rl_tima_ignored");
        wr_reg(16'hFF06, 8'h3C);
        rd_chk(16'hFF05, 8'h3C, "rl_tma_tima");
        rd_chk(16'hFF06, 8'h3C, "rl_tma");
        end_test(1, "rl");

        // Reset in the middle of OVF: no pulse, everything cleared
        setup_ab();
        wait_until(34);
        do_reset();
        rd_chk(16'hFF05, 8'h00, "mid_tima");
        rd_chk(16'hFF06, 8'h00, "mid_tma");
        rd_chk(16'hFF07, 8'hF8, "mid_tac");
        wait_until(20);
        end_test(0, "mid");

        // DIV window and clear
        do_reset();
        wait_until(1023);
        rd_chk(16'hFF04, 8'h03, "div_1023");
        rd_chk(16'hFF04, 8'h04, "div_1024");
        wr_reg(16'hFF04, 8'h9C);
        rd_chk(16'hFF04, 8'h00, "div_clear");
        end_test(0, "div");

        // DIV clear while div_cnt[9]=1 with TAC=100 gives one increment
        do_reset();
        wr_reg(16'hFF07, 8'h04);
        wait_until(599);
        rd_chk(16'hFF05, 8'h00, "divg_before");
        wr_reg(16'hFF04, 8'h00);
        rd_chk(16'hFF05, 8'h01, "divg_after");
        wait_until(1624);
        rd_chk(16'hFF05, 8'h01, "divg_hold");
        rd_chk(16'hFF05, 8'h02, "divg_next");
        end_test(0, "divg");

        // Disabling TAC while the tap is 1 gives one increment; read decode
        do_reset();
        wr_reg(16'hFF07, 8'h05);
        wait_until(9);
        rd_chk(16'hFF05, 8'h00, "tacg_before");
        wr_reg(16'hFF07, 8'h01);
        rd_chk(16'hFF05, 8'h01, "tacg_after");
        rd_chk(16'hFF07, 8'hF9, "tacg_tac");
        rd_chk(16'hFF08, 8'hFF, "tacg_ff08");
        wr_reg(16'hFF03, 8'hAA);
        rd_chk(16'hFF05, 8'h01, "tacg_ff03");
        wait_until(40);
        rd_chk(16'hFF05, 8'h01, "tacg_stopped");
        end_test(0, "tacg");

        // Switching the tap from 1 to 0 gives one increment
        do_reset();
        wr_reg(16'hFF07, 8'h05);
        wait_until(10);
        wr_reg(16'hFF07, 8'h04);
        rd_chk(16'hFF05, 8'h01, "tapsw");
        rd_chk(16'hFF07, 8'hFC, "tapsw_tac");
        end_test(0, "tapsw");

        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rd_pending got=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer.md
Name: timer

Overview:
- DMG timer/divider peripheral; a bus slave on the CPU bus at FF04–FF07.
- Sources the timer interrupt request, bit 2 of the IF register, in the top level, replacing the tied-off request.
- Implements a free-running 16-bit divider with DIV as a readable window, and TIMA/TMA/TAC with hardware-accurate falling-edge increment and delayed overflow reload.

Parameters:
- None.

Ports:
- clk  in  1  4.19 MHz system clock
- rst  in  1  reset; asynchronous, active-high
- a  in  16  bus address
- din  in  8  write data from bus master
- dout  out  8  read data, combinational from `a`
- rd  in  1  read strobe; informational, `dout` is valid regardless
- wr  in  1  write strobe, sampled at posedge clk
- int_tim_req  out  1  timer interrupt request; one-clk pulse

Behaviour:
- Reset (rst high, asynchronous):
  - Registers: div_cnt=16'h0000, TIMA=00, TMA=00, TAC=000.
  - State and flags: state=IDLE, prev_sig=0, int_tim_req=0.
- Register map, read (`dout`):
  - FF04 = div_cnt[15:8]
  - FF05 = TIMA
  - FF06 = TMA
  - FF07 = {5'b11111, TAC[2:0]}
  - Any other address = FF
- div_cnt: increments by 1 every clk and wraps FFFF->0000. Any write to FF04 clears it to 0000 regardless of din; the clear wins over the increment.
- Tap select by TAC[1:0]:
  - 00 -> div_cnt[9] (4096 Hz)
  - 01 -> div_cnt[3] (262144 Hz)
  - 10 -> div_cnt[5] (65536 Hz)
  - 11 -> div_cnt[7] (16384 Hz)
- Increment signal:
  - sig = TAC[2] & tap, computed from next-cycle values, i.e. after any DIV clear or TAC write that takes effect at this edge.
  - prev_sig is registered each clk.
  - inc = prev_sig & ~sig (falling edge).
  - Consequences (required DMG glitches): clearing DIV while the tap is 1, disabling TAC[2] while the tap is 1, or switching tap from 1 to 0 each produce one increment.
- States: IDLE, OVF, RELOAD; a 2-bit sub-counter runs in OVF and RELOAD.
- IDLE:
  - On inc: TIMA<=TIMA+1. If TIMA was FF: TIMA<=00, enter OVF with cnt=3.
  - A write to FF05 in the same cycle as inc wins; no overflow is started.
- OVF (4 clks, TIMA reads 00):
  - Cycles 1–3: hold, cnt decrements.
  - On the edge ending the cnt=0 cycle: TIMA<=TMA, int_tim_req<=1, enter RELOAD with cnt=3.
  - A write to FF05 during OVF: TIMA<=din, abort to IDLE, no reload, no interrupt.
  - inc events during OVF are dropped.
- RELOAD (4 clks):
  - Writes to FF05 are ignored.
  - Writes to FF06 update both TMA and TIMA.
  - inc events are dropped.
  - Returns to IDLE after 4 clks.
- int_tim_req: registered, high for exactly one clk (the first RELOAD cycle), otherwise 0. No ack; the IF logic latches the pulse.
- TMA write: takes effect next edge; in IDLE/OVF it does not touch TIMA, so the reload at OVF end uses the newest TMA.
- TAC write: only din[2:0] are stored.
- Writes to unmapped addresses: no effect.
- Reset mid-OVF/RELOAD: all state cleared immediately, no pulse emitted.

Test Plan:
- Reset, then TAC=3'b101 (enable, /16):
  - TIMA increments every 16 clks.
  - 256 ticks after TIMA=00 the sequence is: TIMA reads 00 for 4 clks, then TMA.
  - int_tim_req is high exactly 1 clk.
- TMA=AB, TIMA=FE, TAC=101:
  - After 2 increments TIMA = 00 for 4 clks, then AB.
  - Exactly one int_tim_req pulse, asserted 4 clks after the overflow edge.
- Overflow abort: write TIMA=55 during the 2nd OVF clk:
  - TIMA = 55, no reload, int_tim_req stays 0.
  - Write TIMA=77 during RELOAD: ignored, TIMA stays at the TMA value.
- DIV:
  - After reset run 1024 clks -> FF04 reads 04.
  - Write FF04=9C -> reads 00 next cycle.
  - With TAC=100 and div_cnt[9]=1, the DIV write increments TIMA by exactly 1.
- TAC glitch: TAC=101 with div_cnt[3]=1, write TAC=001 -> TIMA +1. Reads:
  - FF07 returns F9.
  - FF08 returns FF.
  - FF05 is unaffected by writes to FF03.
